fmadd_mantissa_normalizer: RTL and testbench



---
 rtl/fmadd_mantissa_normalizer.sv | 149 ++++++++++++++
 tb/tb_fmadd_mantissa_normalizer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fmadd_mantissa_normalizer.sv
// Post-adder normalizer: carry right-shift or iterative left shifts (8 or 1 bit/cycle), exponent adjust.
// Latency 1 (zero), 2 (carry), 2..14 (shift); single word in flight, result held in DONE until out_ready.
module fmadd_mantissa_normalizer #(
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*man+3:0]     in_mantissa,
  input  logic                 in_carry,
  input  logic [exp:0]         in_exponent,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*man+3:0]     out_mantissa,
  output logic [exp:0]         out_exponent,
  output logic                 out_sticky,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_zero
);

  localparam int W  = 2*man+4;
  localparam int EW = exp+1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CARRY = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [EW-1:0] EXP_MAX    = '1;
  localparam logic [EW-1:0] EXP_MAX_M1 = {{(EW-1){1'b1}}, 1'b0};
  localparam logic [EW-1:0] EXP_ONE    = EW'(1);
  localparam logic [EW-1:0] EXP_EIGHT  = EW'(8);

  logic [1:0]    state, n_state;
  logic [W-1:0]  mant_q, n_mant;
  logic [EW-1:0] expo_q, n_expo;
  logic          sticky_q, n_sticky;
  logic          ovf_q, n_ovf;
  logic          unf_q, n_unf;
  logic          zero_q, n_zero;
  logic          load_out;

  always_comb begin
    n_state  = state;
    n_mant   = mant_q;
    n_expo   = expo_q;
    n_sticky = sticky_q;
    n_ovf    = ovf_q;
    n_unf    = unf_q;
    n_zero   = zero_q;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          n_mant   = in_mantissa;
          n_expo   = in_exponent;
          n_sticky = 1'b0;
          n_ovf    = 1'b0;
          n_unf    = 1'b0;
          n_zero   = 1'b0;
          if (in_carry) begin
            n_state = ST_CARRY;
          end else if (in_mantissa == '0) begin
            n_expo  = '0;
            n_zero  = 1'b1;
            n_state = ST_DONE;
          end else begin
            n_state = ST_SHIFT;
          end
        end
      end
      ST_CARRY: begin
        n_mant   = {1'b1, mant_q[W-1:1]};
        n_sticky = mant_q[0];
        if (expo_q == EXP_MAX_M1) begin
          n_expo = EXP_MAX;
          n_mant = '0;
          n_ovf  = 1'b1;
        end else begin
          n_expo = expo_q + EXP_ONE;
        end
        n_state = ST_DONE;
      end
      ST_SHIFT: begin
        // Priority: normalized, then denormal stop, then coarse 8-bit step, then fine step.
        if (mant_q[W-1]) begin
          n_state = ST_DONE;
        end else if (expo_q <= EXP_ONE) begin
          n_expo  = '0;
          n_unf   = 1'b1;
          n_state = ST_DONE;
        end else if ((mant_q[W-1 -: 8] == 8'd0) && (expo_q > EXP_EIGHT)) begin
          n_mant = {mant_q[W-9:0], 8'd0};
          n_expo = expo_q - EXP_EIGHT;
        end else begin
          n_mant = {mant_q[W-2:0], 1'b0};
          n_expo = expo_q - EXP_ONE;
        end
      end
      ST_DONE: begin
        if (out_ready) n_state = ST_IDLE;
      end
      default: n_state = ST_IDLE;
    endcase
  end

  // Result registers update only when a word completes, so they hold between words.
  assign load_out = (n_state == ST_DONE) && (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mant_q        <= '0;
      expo_q        <= '0;
      sticky_q      <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      zero_q        <= 1'b0;
      out_mantissa  <= '0;
      out_exponent  <= '0;
      out_sticky    <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_zero      <= 1'b0;
    end else begin
      state    <= n_state;
      mant_q   <= n_mant;
      expo_q   <= n_expo;
      sticky_q <= n_sticky;
      ovf_q    <= n_ovf;
      unf_q    <= n_unf;
      zero_q   <= n_zero;
      if (load_out) begin
        out_mantissa  <= n_mant;
        out_exponent  <= n_expo;
        out_sticky    <= n_sticky;
        out_overflow  <= n_ovf;
        out_underflow <= n_unf;
        out_zero      <= n_zero;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_fmadd_mantissa_normalizer.sv
// Randomized bench for fmadd_mantissa_normalizer against a leading-zero-count reference model.
module tb_fmadd_mantissa_normalizer;

  localparam int W  = 48;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mantissa;
  logic          in_carry;
  logic [EW-1:0] in_exponent;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_mantissa;
  logic [EW-1:0] out_exponent;
  logic          out_sticky;
  logic          out_overflow;
  logic          out_underflow;
  logic          out_zero;

  int n_checks = 0;
  int n_errors = 0;

  fmadd_mantissa_normalizer #(.man(22), .exp(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mantissa(in_mantissa), .in_carry(in_carry), .in_exponent(in_exponent),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mantissa(out_mantissa), .out_exponent(out_exponent),
    .out_sticky(out_sticky), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: works on the leading-zero count rather than on mantissa bits.
  task automatic model(input logic [W-1:0] m, input logic c, input logic [EW-1:0] e,
                       output logic [W-1:0] om, output logic [EW-1:0] oe,
                       output logic os, output logic ov, output logic un, output logic z,
                       output int lat);
    int lz, sh, ee, steps;
    om = '0; oe = '0; os = 0; ov = 0; un = 0; z = 0; lat = 0;
    if (c) begin
      lat = 2;
      os  = m[0];
      if (e == 8'd254) begin
        oe = 8'd255; om = '0; ov = 1;
      end else begin
        oe = e + 8'd1;
        om = (m >> 1) + (48'd1 << 47);
      end
    end else if (m == 0) begin
      lat = 1; z = 1;
    end else begin
      lz = 0;
      while (lz < W && m[W-1-lz] == 1'b0) lz++;
      sh = 0; ee = int'(e); steps = 0;
      while (sh < lz) begin
        if (ee <= 1) begin
          un = 1; ee = 0;
          break;
        end
        if ((lz - sh) >= 8 && ee > 8) begin
          sh += 8; ee -= 8;
        end else begin
          sh += 1; ee -= 1;
        end
        steps++;
      end
      if (sh == lz && ee <= 1 && lz > 0 && un == 0) ee = ee; // fully normalized: no underflow stop
      om  = m << sh;
      oe  = EW'(ee);
      lat = steps + 2;
    end
  endtask

  task automatic run_word(input logic [W-1:0] m, input logic c, input logic [EW-1:0] e,
                          input int hold);
    logic [W-1:0]  em;
    logic [EW-1:0] ee;
    logic es, eo, eu, ez;
    int elat, lat, t;
    model(m, c, e, em, ee, es, eo, eu, ez, elat);
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid    = 1'b1;
    in_mantissa = m;
    in_carry    = c;
    in_exponent = e;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("mantissa", out_mantissa, em);
    check("exponent", out_exponent, ee);
    check("sticky", out_sticky, es);
    check("overflow", out_overflow, eo);
    check("underflow", out_underflow, eu);
    check("zero", out_zero, ez);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_mantissa", out_mantissa, em);
      check("bp_exponent", out_exponent, ee);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_hold", out_mantissa, em);
  endtask

  initial begin
    logic [W-1:0] r, m;
    logic [EW-1:0] e;
    logic c;
    int mode, hold;
    bit seen;

    rst = 1'b1; in_valid = 1'b0; in_mantissa = '0; in_carry = 1'b0;
    in_exponent = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mantissa", out_mantissa, 0);
    check("rst_flags", {out_exponent, out_sticky, out_overflow, out_underflow, out_zero}, 0);

    run_word(48'h800000000000, 1'b1, 8'd127, 0);
    run_word(48'h000000000001, 1'b1, 8'd254, 0);
    run_word(48'h000010000000, 1'b0, 8'd100, 0);
    run_word(48'h000000000001, 1'b0, 8'd5,   0);
    run_word(48'h000000000000, 1'b0, 8'd77,  3);
    run_word(48'h000000000001, 1'b0, 8'd200, 0);
    run_word(48'h000000000001, 1'b1, 8'd60,  0);

    // Abort a long shift with reset; the word must never appear.
    in_valid = 1'b1; in_mantissa = 48'h000000000001; in_carry = 1'b0; in_exponent = 8'd200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_mantissa", out_mantissa, 0);
    check("mid_rst_flags", {out_exponent, out_sticky, out_overflow, out_underflow, out_zero}, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_output", seen, 0);

    for (int i = 0; i < 200; i++) begin
      mode = $urandom_range(0, 7);
      r    = {16'($urandom), $urandom};
      e    = 8'($urandom_range(0, 255));
      c    = 1'b0;
      m    = r >> $urandom_range(0, 47);
      if (m == 0) m = 48'd1;
      if (mode == 0) m = '0;
      if (mode == 1) c = 1'b1;
      if (mode == 2) begin
        c = 1'b1; e = 8'd254;
      end
      hold = (i % 3 == 0) ? $urandom_range(1, 3) : 0;
      run_word(m, c, e, hold);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
